// File: rtl/col_to_row_acc.sv
// Purpose: turns transposed column vectors back into normalised row limbs and appends a carry-flush limb at the end of each frame.
// Latency: 1 cycle from beat acceptance to out_valid; one input bubble per frame while the carry limb is emitted.
// Backpressure: out_ready low holds the output register and drops in_ready; no beat is lost or duplicated.
module col_to_row_acc #(
  parameter  int BIT_LEN   = 17,
  parameter  int NUM_ROWS  = 62,
  parameter  int NUM_BEATS = 123,
  localparam int CARRY_LEN = $clog2(NUM_ROWS) + 1,
  localparam int IDX_LEN   = $clog2(NUM_BEATS + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [BIT_LEN-1:0][NUM_ROWS-1:0]  in_cols,
  input  logic                              in_last,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [BIT_LEN-1:0]                out_limb,
  output logic [IDX_LEN-1:0]                out_idx,
  output logic                              out_last,
  output logic                              proto_err
);

  // Popcount of one column fits in PC_LEN bits; the weighted sum plus carry
  // never exceeds NUM_ROWS * 2^BIT_LEN, so SUM_LEN bits hold it exactly and
  // the carry slice sum[SUM_LEN-1:BIT_LEN] is CARRY_LEN bits wide.
  localparam int PC_LEN  = $clog2(NUM_ROWS + 1);
  localparam int SUM_LEN = BIT_LEN + CARRY_LEN;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                 state_q, state_d;
  logic [CARRY_LEN-1:0]   carry_q, carry_d;
  logic [IDX_LEN-1:0]     cnt_q, cnt_d;
  logic                   out_valid_d, out_last_d, proto_err_d;
  logic [BIT_LEN-1:0]     out_limb_d;
  logic [IDX_LEN-1:0]     out_idx_d;
  logic [SUM_LEN-1:0]     beat_sum;
  logic                   load, accept, last_beat;

  function automatic logic [PC_LEN-1:0] popcnt(input logic [NUM_ROWS-1:0] v);
    logic [PC_LEN-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_ROWS; i++) c = c + PC_LEN'(v[i]);
    return c;
  endfunction

  assign load      = !out_valid || out_ready;
  assign in_ready  = (state_q == RUN) && load;
  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt_q == IDX_LEN'(NUM_BEATS - 1));

  // Column popcounts weighted by bit position, plus the carry from the previous limb.
  always_comb begin
    beat_sum = SUM_LEN'(carry_q);
    for (int k = 0; k < BIT_LEN; k++) begin
      beat_sum = beat_sum + (SUM_LEN'(popcnt(in_cols[k])) << k);
    end
  end

  // Next-state and output-register logic for the RUN/FLUSH sequencer.
  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid;
    out_limb_d  = out_limb;
    out_idx_d   = out_idx;
    out_last_d  = out_last;
    proto_err_d = proto_err;

    // The held limb drains; it is replaced below if something new loads.
    if (out_valid && out_ready) out_valid_d = 1'b0;

    case (state_q)
      RUN: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_limb_d  = beat_sum[BIT_LEN-1:0];
          out_idx_d   = cnt_q;
          out_last_d  = 1'b0;
          carry_d     = beat_sum[SUM_LEN-1:BIT_LEN];
          cnt_d       = cnt_q + IDX_LEN'(1);
          if (in_last || last_beat) state_d = FLUSH;
          // in_last must coincide exactly with the final permitted beat.
          if (in_last != last_beat) proto_err_d = 1'b1;
        end
      end
      FLUSH: begin
        if (load) begin
          out_valid_d = 1'b1;
          out_limb_d  = BIT_LEN'(carry_q);
          out_idx_d   = cnt_q;
          out_last_d  = 1'b1;
          carry_d     = '0;
          cnt_d       = '0;
          state_d     = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State, accumulator and output registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      carry_q   <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_limb  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      out_valid <= out_valid_d;
      out_limb  <= out_limb_d;
      out_idx   <= out_idx_d;
      out_last  <= out_last_d;
      proto_err <= proto_err_d;
    end
  end

endmodule

// File: doc/col_to_row_acc.md
Name: col_to_row_acc

Overview:
- Inverse of the partial-product row-to-column transpose stage. Accepts transposed column bit-vectors one limb-group per beat, least-significant group first.
- Popcounts each column and weights it by its bit position within the limb. Adds the running inter-limb carry.
- Emits one normalised BIT_LEN-bit limb per beat, so the column form is reassembled into a row of word limbs.
- After the frame's final beat, emits the residual carry as one extra limb. Feeds the limb-serial reduction path of the modular squarer.

Parameters:
- BIT_LEN, 17, limb width and number of columns per beat.
- NUM_ROWS, 62, column height (bits per column vector).
- NUM_BEATS, 123, maximum beats per frame (2*NUM_ROWS-1).
- CARRY_LEN, $clog2(NUM_ROWS)+1, width of the carry register (localparam).
- IDX_LEN, $clog2(NUM_BEATS+1), width of the limb index (localparam).

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, input beat valid.
- in_ready, out, 1, input beat accepted when in_valid && in_ready.
- in_cols, in, [BIT_LEN-1:0][NUM_ROWS-1:0], in_cols[k] is the column vector for bit k of the current limb.
- in_last, in, 1, final beat of the frame.
- out_valid, out, 1, out_limb valid.
- out_ready, in, 1, downstream accepts out_limb.
- out_limb, out, BIT_LEN, normalised limb.
- out_idx, out, IDX_LEN, limb index within the frame (0-based).
- out_last, out, 1, final limb of the frame (the carry flush limb).
- proto_err, out, 1, sticky protocol error flag; cleared only by reset.

Behaviour:
- Reset, asynchronous on rst_n low:
  - out_valid=0, out_limb=0, out_idx=0, out_last=0, proto_err=0.
  - carry=0, beat counter=0, state=RUN.
  - Reset mid-frame discards all partial state; no limb is emitted for the aborted frame.
- States:
  - RUN: accepting beats.
  - FLUSH: emitting the carry limb.
- Output register load condition: load = !out_valid || out_ready.
- in_ready = (state==RUN) && load. in_ready is 0 in FLUSH.
- Beat accepted in RUN:
  - sum = carry + Σ_k popcount(in_cols[k]) << k, for k = 0..BIT_LEN-1.
  - Next cycle: out_limb=sum[BIT_LEN-1:0], out_idx=beat counter, out_valid=1, out_last=0.
  - carry <= sum >> BIT_LEN. This is guaranteed ≤ NUM_ROWS and fits CARRY_LEN; no truncation is allowed.
  - Beat counter increments.
- End of frame:
  - A frame ends when a beat with in_last=1 is accepted, or when beat NUM_BEATS-1 is accepted.
  - Either event moves the state to FLUSH.
  - proto_err is set if in_last=1 on a beat other than NUM_BEATS-1, or if in_last=0 on beat NUM_BEATS-1 (forced end).
- FLUSH, when load is true:
  - out_limb = zero-extended carry, out_idx = beat count, out_last=1, out_valid=1.
  - Then carry=0, counter=0, state=RUN.
- Latency: 1 cycle from acceptance to out_valid. Full throughput is one beat per cycle while out_ready=1. One bubble cycle per frame on input for the flush.
- Backpressure:
  - out_valid=1 && out_ready=0 holds out_limb, out_idx and out_last stable, and holds in_ready low.
  - No beat is lost or duplicated.
- Simultaneous events: out_ready and in_valid both high in the same cycle means the old limb drains and the new limb loads in that same cycle.
- in_cols is sampled only on acceptance. in_valid held high with in_ready=0 causes no state change.

Test Plan:
- Single beat, in_last=1, all in_cols=0 -> limb0=0 (idx0), then flush limb=0 (idx1, out_last=1); proto_err=1.
- Single beat, in_last=1, in_cols[0] with 5 bits set and in_cols[16] with 62 bits set:
  - sum = 5 + 62·65536 = 4063237, carry = 31.
  - Outputs: limb0=0x00005, flush limb=31, proto_err=1.
- Full 123-beat frame, every column all-ones, in_last only on beat 122, out_ready=1:
  - Each beat adds 62·(2^17-1) plus the carry.
  - Limbs match a reference big-integer sum; 124 limbs total; carry-flush limb idx 123 with out_last=1.
  - In-frame limbs arrive back-to-back; proto_err=0.
- Same frame with out_ready toggled randomly at 50% -> identical limb sequence, no drops or duplicates, outputs stable while stalled.
- 123 beats with in_last never asserted -> forced FLUSH after beat 122, flush limb emitted, proto_err=1.
- rst_n pulsed low mid-frame at beat 40 -> all outputs 0 asynchronously; next frame starts at idx 0 with carry 0 and matches the reference.
